// File: rtl/alu_sequencer.sv
// Fetch/execute control sequencer for one register-to-register ALU instruction per start.
// Optional two-word HI/LO writeback for mul/div is enabled by defining ALU_SEQ_MULDIV_EN.
module alu_sequencer #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREG     = 16,
  parameter int unsigned OPCODE_W = 5,
  parameter int unsigned RSEL_W   = $clog2(NREG)
) (
  input  logic                Clock,
  input  logic                Clear_n,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   ir,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [NREG-1:0]     Rin,
  output logic [NREG-1:0]     Rout,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                busy,
  output logic                done,
  output logic                fault
);

  localparam int unsigned RA_HI = DATA_W - 1 - OPCODE_W;
  localparam int unsigned RB_HI = RA_HI - RSEL_W;
  localparam int unsigned RC_HI = RB_HI - RSEL_W;
  localparam int unsigned LOW_W = RC_HI + 1 - RSEL_W;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_DEC, S_T4, S_T5, S_T6, S_T7, S_FAULT
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlow_out;
    logic zhigh_out;
    logic hi_in;
    logic lo_in;
  } strobe_t;

  state_t                state_q, state_d;
  strobe_t               strb_q, strb_d;
  logic [NREG-1:0]       rin_q, rin_d, rout_q, rout_d;
  logic [OPCODE_W-1:0]   op_q, op_d;
  logic                  busy_q, busy_d, done_q, done_d, fault_q, fault_d;

  logic [OPCODE_W-1:0]   op;
  logic [RSEL_W-1:0]     ra, rb, rc;
  logic                  legal;
  logic                  muldiv;

  // Instruction field decode
  assign op = ir[DATA_W-1 -: OPCODE_W];
  assign ra = ir[RA_HI -: RSEL_W];
  assign rb = ir[RB_HI -: RSEL_W];
  assign rc = ir[RC_HI -: RSEL_W];

  if (LOW_W > 0) begin : g_unused
    logic unused_ir_low;
    assign unused_ir_low = ^ir[LOW_W-1:0];
  end

`ifdef ALU_SEQ_MULDIV_EN
  assign muldiv = (op == OPCODE_W'(15)) || (op == OPCODE_W'(16));
`else
  assign muldiv = 1'b0;
`endif
  assign legal = ((op >= OPCODE_W'(3)) && (op <= OPCODE_W'(11))) || muldiv;

  // Next state plus registered Moore outputs decoded from the state being entered
  always_comb begin
    state_d = state_q;
    strb_d  = '0;
    rin_d   = '0;
    rout_d  = '0;
    op_d    = '0;
    done_d  = 1'b0;
    fault_d = fault_q;

    case (state_q)
      S_IDLE:  if (start) begin
                 state_d = S_T0;
                 fault_d = 1'b0;
               end
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    if (mem_ready) state_d = S_T3;
      S_T3:    state_d = S_DEC;
      S_DEC:   state_d = legal ? S_T4 : S_FAULT;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = S_T6;
      S_T6:    state_d = muldiv ? S_T7 : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_T0: begin
        strb_d.pc_out = 1'b1;
        strb_d.mar_in = 1'b1;
        strb_d.inc_pc = 1'b1;
        strb_d.z_in   = 1'b1;
      end
      S_T1: begin
        strb_d.zlow_out = 1'b1;
        strb_d.pc_in    = 1'b1;
      end
      S_T2: begin
        strb_d.read   = 1'b1;
        strb_d.mdr_in = 1'b1;
      end
      S_T3: begin
        strb_d.mdr_out = 1'b1;
        strb_d.ir_in   = 1'b1;
      end
      S_T4: begin
        rout_d      = NREG'(1) << rb;
        strb_d.y_in = 1'b1;
      end
      S_T5: begin
        rout_d      = NREG'(1) << rc;
        op_d        = op;
        strb_d.z_in = 1'b1;
      end
      S_T6: begin
        strb_d.zlow_out = 1'b1;
        if (muldiv) begin
          strb_d.lo_in = 1'b1;
        end else begin
          rin_d  = NREG'(1) << ra;
          done_d = 1'b1;
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      S_T7: begin
        strb_d.zhigh_out = 1'b1;
        strb_d.hi_in     = 1'b1;
        done_d           = 1'b1;
      end
`endif
      S_FAULT: begin
        done_d  = 1'b1;
        fault_d = 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q <= S_IDLE;
      strb_q  <= '0;
      rin_q   <= '0;
      rout_q  <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      strb_q  <= strb_d;
      rin_q   <= rin_d;
      rout_q  <= rout_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign PCout    = strb_q.pc_out;
  assign MARin    = strb_q.mar_in;
  assign IncPC    = strb_q.inc_pc;
  assign PCin     = strb_q.pc_in;
  assign Read     = strb_q.read;
  assign MDRin    = strb_q.mdr_in;
  assign MDRout   = strb_q.mdr_out;
  assign IRin     = strb_q.ir_in;
  assign Yin      = strb_q.y_in;
  assign Zin      = strb_q.z_in;
  assign Zlowout  = strb_q.zlow_out;
  assign Zhighout = strb_q.zhigh_out;
  assign HIin     = strb_q.hi_in;
  assign LOin     = strb_q.lo_in;
  assign Rin      = rin_q;
  assign Rout     = rout_q;
  assign alu_op   = op_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fault    = fault_q;

endmodule
